frame_draw_point_bridge: RTL and testbench

- Converts the sensor-side pixel stream (frame valid, line valid, pixel strobe, mono/raw pixel) into draw-point commands (x, y, colour) for the VGA-side draw-point bus.
- Next generation of the fixed camera-to-VGA path: parametrised pixel/coordinate widths, X/Y decimation, selectable skip/average mode, buffered output with valid/ready backpressure, and overflow accounting.
- Sits between the image sensor driver and the VGA driver. Both run on the system clock.

---
 rtl/frame_bridge_pkg.sv | 16 +
 rtl/sync_fifo.sv | 42 ++++
 rtl/frame_draw_point_bridge.sv | 138 +++++++++++++
 tb/tb_frame_draw_point_bridge.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_bridge_pkg.sv
// frame_bridge_pkg: shared types and helpers for the sensor-to-draw-point bridge
package frame_bridge_pkg;
    localparam int PIX_W_DEF = 12;
    localparam int COL_W_DEF = 8;
    localparam int X_W_DEF = 10;
    localparam int Y_W_DEF = 9;
    typedef struct packed {
        logic [X_W_DEF-1:0] x;
        logic [Y_W_DEF-1:0] y;
        logic [COL_W_DEF-1:0] color;
    } point_t;
    typedef enum logic {IDLE, FRAME} state_t;
    function automatic int dec_shift(input int decim);
        return $clog2(decim);
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO, full/empty from an extra pointer bit
module sync_fifo #(
    parameter int W = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW:0] wr_q, wr_d, rd_q, rd_d;
    logic push, pull;
    always_comb begin
        full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        empty = wr_q == rd_q;
        pull = rd_en & ~empty;
        // a pop frees the slot being written, so a full FIFO still accepts
        push = wr_en & (~full | pull);
        mem_d = mem_q;
        if (push) mem_d[wr_q[AW-1:0]] = wr_data;
        wr_d = wr_q + (AW+1)'(push);
        rd_d = rd_q + (AW+1)'(pull);
        rd_data = mem_q[rd_q[AW-1:0]];
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
        mem_q <= mem_d;
    end
endmodule

// File: rtl/frame_draw_point_bridge.sv
// frame_draw_point_bridge: decimates a sensor pixel stream into buffered draw-point commands
module frame_draw_point_bridge
    import frame_bridge_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int COL_W = COL_W_DEF,
    parameter int X_W = X_W_DEF,
    parameter int Y_W = Y_W_DEF,
    parameter int DECIM_X = 2,
    parameter int DECIM_Y = 2,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             piul1Clock,
    input  logic             piul1Reset_n,
    input  logic             piul1FrameValid,
    input  logic             piul1LineValid,
    input  logic             piul1PixelValid,
    input  logic [PIX_W-1:0] piulPixelData,
    input  logic             piul1AvgMode,
    input  logic             piul1ClearStats,
    output logic             poul1PointValid,
    input  logic             piul1PointReady,
    output logic [X_W-1:0]   poulPointX,
    output logic [Y_W-1:0]   poulPointY,
    output logic [COL_W-1:0] poulPointColor,
    output logic             poul1FrameDone,
    output logic [CNT_W-1:0] poulFrameCount,
    output logic [CNT_W-1:0] poulDropCount,
    output logic             poul1Overflow
);
    localparam int SHX = dec_shift(DECIM_X);
    localparam int SHY = dec_shift(DECIM_Y);
    localparam int SX_W = X_W + SHX;
    localparam int SY_W = Y_W + SHY;
    localparam int ACC_W = PIX_W + SHX;
    localparam int PT_W = X_W + Y_W + COL_W;
    localparam logic [SX_W-1:0] X_MASK = SX_W'(DECIM_X - 1);
    localparam logic [SY_W-1:0] Y_MASK = SY_W'(DECIM_Y - 1);
    state_t state_q, state_d;
    logic fv_q, lv_q, avg_q, avg_d, emit_q, emit_d, done_q, done_d, ovf_q, ovf_d;
    logic [SX_W-1:0] src_x_q, src_x_d;
    logic [SY_W-1:0] src_y_q, src_y_d;
    logic [ACC_W-1:0] acc_q, acc_d, sum;
    logic [PT_W-1:0] pt_q, pt_d, head;
    logic [CNT_W-1:0] frames_q, frames_d, drops_q, drops_d;
    logic fv_rise, fv_fall, lv_fall, pix_ok, phase0, last, kept, full, empty, pop, drop;
    always_comb begin
        fv_rise = piul1FrameValid & ~fv_q;
        fv_fall = ~piul1FrameValid & fv_q;
        lv_fall = ~piul1LineValid & lv_q;
        pix_ok = (state_q == FRAME) & piul1FrameValid & piul1LineValid & piul1PixelValid;
        phase0 = (src_x_q & X_MASK) == '0;
        last = (src_x_q & X_MASK) == X_MASK;
        kept = (src_y_q & Y_MASK) == '0;
        // group sum restarts on the first pixel of each DECIM_X group
        sum = (phase0 ? '0 : acc_q) + ACC_W'(piulPixelData);
        state_d = state_q;
        avg_d = avg_q;
        src_x_d = src_x_q;
        src_y_d = src_y_q;
        acc_d = acc_q;
        done_d = 1'b0;
        frames_d = frames_q;
        emit_d = pix_ok & kept & (avg_q ? last : phase0);
        pt_d = {src_x_q[SX_W-1:SHX], src_y_q[SY_W-1:SHY],
                avg_q ? sum[ACC_W-1 -: COL_W] : piulPixelData[PIX_W-1 -: COL_W]};
        if (fv_rise) begin
            state_d = FRAME;
            avg_d = piul1AvgMode;
            src_x_d = '0;
            src_y_d = '0;
        end else if (state_q == FRAME) begin
            if (fv_fall) begin
                state_d = IDLE;
                done_d = 1'b1;
                frames_d = frames_q + 1'b1;
            end else if (lv_fall) begin
                src_x_d = '0;
                src_y_d = src_y_q + 1'b1;
            end else if (pix_ok) begin
                src_x_d = src_x_q + 1'b1;
                acc_d = sum;
            end
        end
        pop = ~empty & piul1PointReady;
        drop = emit_q & full & ~pop;
        drops_d = piul1ClearStats ? '0 : drops_q + CNT_W'(drop & ~&drops_q);
        ovf_d = ~piul1ClearStats & (ovf_q | drop);
    end
    always_ff @(posedge piul1Clock) begin
        if (!piul1Reset_n) begin
            state_q <= IDLE;
            fv_q <= 1'b0;
            lv_q <= 1'b0;
            avg_q <= 1'b0;
            src_x_q <= '0;
            src_y_q <= '0;
            acc_q <= '0;
            emit_q <= 1'b0;
            pt_q <= '0;
            done_q <= 1'b0;
            frames_q <= '0;
            drops_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fv_q <= piul1FrameValid;
            lv_q <= piul1LineValid;
            avg_q <= avg_d;
            src_x_q <= src_x_d;
            src_y_q <= src_y_d;
            acc_q <= acc_d;
            emit_q <= emit_d;
            pt_q <= pt_d;
            done_q <= done_d;
            frames_q <= frames_d;
            drops_q <= drops_d;
            ovf_q <= ovf_d;
        end
    end
    sync_fifo #(.W(PT_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (piul1Clock),
        .rst_n  (piul1Reset_n),
        .wr_en  (emit_q),
        .wr_data(pt_q),
        .rd_en  (pop),
        .rd_data(head),
        .full   (full),
        .empty  (empty)
    );
    assign poul1PointValid = ~empty;
    assign {poulPointX, poulPointY, poulPointColor} = empty ? '0 : head;
    assign poul1FrameDone = done_q;
    assign poulFrameCount = frames_q;
    assign poulDropCount = drops_q;
    assign poul1Overflow = ovf_q;
endmodule

// File: tb/tb_frame_draw_point_bridge.sv
// tb_frame_draw_point_bridge: scoreboard bench for the draw-point bridge
module tb_frame_draw_point_bridge;
    logic clk = 0, rst_n = 0, fv = 0, lv = 0, pv = 0, avg = 0, clr = 0, rdy = 0;
    logic [11:0] pix = '0;
    logic pvld, done, ovf;
    logic [9:0] px;
    logic [8:0] py;
    logic [7:0] pc;
    logic [15:0] fcnt, dcnt;
    int checks = 0, errors = 0, popped = 0, done_cnt = 0;
    logic [26:0] exp_q[$];
    logic [26:0] e;
    bit model_avg = 0, use_line = 0;
    logic [11:0] line_pix [0:63];

    always #5 clk = ~clk;

    frame_draw_point_bridge dut (
        .piul1Clock(clk), .piul1Reset_n(rst_n), .piul1FrameValid(fv), .piul1LineValid(lv),
        .piul1PixelValid(pv), .piulPixelData(pix), .piul1AvgMode(avg), .piul1ClearStats(clr),
        .poul1PointValid(pvld), .piul1PointReady(rdy), .poulPointX(px), .poulPointY(py),
        .poulPointColor(pc), .poul1FrameDone(done), .poulFrameCount(fcnt),
        .poulDropCount(dcnt), .poul1Overflow(ovf)
    );

    function automatic logic [11:0] pval(int x, int y);
        return use_line ? line_pix[x] : 12'(12'h100 * x + y);
    endfunction

    function automatic logic [26:0] mk(int x, int y, logic [7:0] c);
        return {10'(x), 9'(y), c};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && done) done_cnt++;
        if (rst_n && pvld && rdy) begin
            checks++;
            popped++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL point_unexpected got x=%0d y=%0d c=%h required none", px, py, pc);
            end else begin
                e = exp_q.pop_front();
                if ({px, py, pc} !== e) begin
                    errors++;
                    $display("FAIL point got x=%0d y=%0d c=%h required x=%0d y=%0d c=%h",
                             px, py, pc, e[26:17], e[16:8], e[7:0]);
                end
            end
        end
    end

    task automatic frame_begin(bit a);
        avg = a;
        model_avg = a;
        fv = 1;
        tick;
        tick;
    endtask

    task automatic frame_end;
        fv = 0;
        lv = 0;
        pv = 0;
        tick;
        tick;
        tick;
    endtask

    task automatic drive_line(int y, int w);
        logic [12:0] s;
        for (int x = 0; x < w; x++) begin
            lv = 1;
            pv = 1;
            pix = pval(x, y);
            if (y % 2 == 0) begin
                if (!model_avg && x % 2 == 0) exp_q.push_back(mk(x / 2, y / 2, pix[11:4]));
                if (model_avg && x % 2 == 1) begin
                    s = ({1'b0, pval(x - 1, y)} + {1'b0, pix}) >> 1;
                    exp_q.push_back(mk(x / 2, y / 2, s[11:4]));
                end
            end
            tick;
        end
        lv = 0;
        pv = 0;
        pix = '0;
        tick;
        tick;
    endtask

    task automatic frame(bit a, int w, int h);
        frame_begin(a);
        for (int y = 0; y < h; y++) drive_line(y, w);
        frame_end;
    endtask

    task automatic wait_drain(string name);
        int n = 0;
        while (pvld && n < 300) begin
            tick;
            n++;
        end
        checks++;
        if (pvld || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain valid=%b left=%0d required valid=0 left=0", name, pvld, exp_q.size());
        end
    endtask

    task automatic test_reset;
        rst_n = 0;
        tick;
        tick;
        checks++;
        if ({pvld, px, py, pc, done, fcnt, dcnt, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0", {pvld, px, py, pc, done, fcnt, dcnt, ovf});
        end
        rst_n = 1;
        tick;
    endtask

    task automatic test_skip;
        int p0 = popped, d0 = done_cnt;
        rdy = 1;
        frame(0, 8, 4);
        wait_drain("skip");
        checks++;
        if (popped - p0 != 8) begin
            errors++;
            $display("FAIL skip_points got %0d required 8", popped - p0);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL skip_done got %0d required 1", done_cnt - d0);
        end
        checks++;
        if (fcnt !== 16'd1) begin
            errors++;
            $display("FAIL skip_framecount got %0d required 1", fcnt);
        end
    endtask

    task automatic test_avg;
        int p0 = popped;
        use_line = 1;
        line_pix[0] = 12'h010;
        line_pix[1] = 12'h030;
        line_pix[2] = 12'h050;
        frame_begin(1);
        drive_line(0, 3);
        frame_end;
        wait_drain("avg");
        use_line = 0;
        checks++;
        if (popped - p0 != 1) begin
            errors++;
            $display("FAIL avg_points got %0d required 1", popped - p0);
        end
        checks++;
        if (fcnt !== 16'd2) begin
            errors++;
            $display("FAIL avg_framecount got %0d required 2", fcnt);
        end
    endtask

    task automatic test_overflow;
        int p0;
        logic [26:0] h;
        rdy = 0;
        frame(0, 8, 10);
        checks++;
        if (dcnt !== 16'd4 || ovf !== 1'b1 || pvld !== 1'b1) begin
            errors++;
            $display("FAIL ovf_stats got drop=%0d ovf=%b valid=%b required drop=4 ovf=1 valid=1", dcnt, ovf, pvld);
        end
        h = exp_q[0];
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({px, py, pc} !== h) begin
                errors++;
                $display("FAIL ovf_head_stable got %h required %h", {px, py, pc}, h);
            end
            tick;
        end
        while (exp_q.size() > 16) void'(exp_q.pop_back());
        p0 = popped;
        rdy = 1;
        wait_drain("ovf");
        checks++;
        if (popped - p0 != 16) begin
            errors++;
            $display("FAIL ovf_drained got %0d required 16", popped - p0);
        end
    endtask

    task automatic test_back_to_back;
        int p0;
        logic [15:0] d0;
        rdy = 0;
        frame(0, 8, 8);
        d0 = dcnt;
        p0 = popped;
        frame_begin(0);
        lv = 1;
        pv = 1;
        pix = pval(0, 0);
        exp_q.push_back(mk(0, 0, pix[11:4]));
        tick;
        pv = 0;
        rdy = 1;
        tick;
        rdy = 0;
        lv = 0;
        tick;
        frame_end;
        checks++;
        if (dcnt !== d0) begin
            errors++;
            $display("FAIL b2b_dropcount got %0d required %0d", dcnt, d0);
        end
        rdy = 1;
        wait_drain("b2b");
        checks++;
        if (popped - p0 != 17) begin
            errors++;
            $display("FAIL b2b_points got %0d required 17", popped - p0);
        end
    endtask

    task automatic test_reset_mid;
        int p0;
        rdy = 0;
        frame_begin(0);
        drive_line(0, 8);
        drive_line(1, 8);
        drive_line(2, 2);
        checks++;
        if (pvld !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_queued got valid=%b required 1", pvld);
        end
        rst_n = 0;
        fv = 0;
        tick;
        checks++;
        if (pvld !== 1'b0 || fcnt !== '0 || dcnt !== '0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_clear got valid=%b frames=%0d drops=%0d ovf=%b required all 0", pvld, fcnt, dcnt, ovf);
        end
        exp_q.delete();
        rst_n = 1;
        tick;
        rdy = 1;
        p0 = popped;
        frame(0, 8, 4);
        wait_drain("rstmid");
        checks++;
        if (popped - p0 != 8 || fcnt !== 16'd1) begin
            errors++;
            $display("FAIL rstmid_refill got points=%0d frames=%0d required points=8 frames=1", popped - p0, fcnt);
        end
    endtask

    task automatic test_clear_and_mode;
        int p0;
        rdy = 0;
        frame(0, 8, 10);
        checks++;
        if (dcnt !== 16'd4 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL clr_pre got drop=%0d ovf=%b required drop=4 ovf=1", dcnt, ovf);
        end
        frame_begin(0);
        lv = 1;
        pv = 1;
        pix = pval(0, 0);
        tick;
        pv = 0;
        clr = 1;
        tick;
        clr = 0;
        lv = 0;
        tick;
        checks++;
        if (dcnt !== '0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL clr_wins got drop=%0d ovf=%b required drop=0 ovf=0", dcnt, ovf);
        end
        frame_end;
        while (exp_q.size() > 16) void'(exp_q.pop_back());
        rdy = 1;
        wait_drain("clr");
        p0 = popped;
        frame_begin(0);
        avg = 1;
        drive_line(0, 4);
        frame_end;
        frame_begin(1);
        drive_line(0, 4);
        frame_end;
        wait_drain("mode");
        checks++;
        if (popped - p0 != 4) begin
            errors++;
            $display("FAIL mode_points got %0d required 4", popped - p0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_skip;
        test_avg;
        test_overflow;
        test_back_to_back;
        test_reset_mid;
        test_clear_and_mode;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
